radar_adc_capture: RTL and testbench

Downstream consumer of the radar pulse controller's adc_enable window. It captures ADC I/Q samples into an internal buffer while adc_enable is high. After the window closes, it emits one AXI-Stream frame per pulse: a 4-word header (pulse index, sample count/flags, timestamp) followed by the captured samples. The frame is sized for the host/DMA path, and pulses that arrive while a frame is still draining are dropped and counted.

---
 rtl/radar_adc_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_radar_adc_capture.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : radar_adc_capture
// Description : Captures ADC I/Q samples during the pulse controller's
//               adc_enable window and emits one AXI-Stream frame per pulse:
//               a 4-word header followed by the captured samples.
// Revision    : 1.0 - initial release
// ============================================================================
module radar_adc_capture #(
    parameter int          FIFO_AW             = 10,
    parameter logic [31:0] CAPTURE_MAX_INIT    = 32'h000001fe,
    parameter logic [7:0]  SR_CAPTURE_MAX_ADDR = 8'd3,
    parameter logic [15:0] HDR_MAGIC           = 16'hADC0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        adc_enable,
    input  logic        adc_valid,
    input  logic [31:0] adc_data,
    input  logic [63:0] timestamp,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] pulse_count,
    output logic [15:0] drop_count,
    output logic        overflow
);

    localparam logic [32:0] DEPTH = 33'd1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HDR     = 2'd2,
        S_DATA    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en2_q, vld_q;
    logic [31:0] dat_q;
    logic [31:0] capture_max_q;
    logic [16:0] limit_q, limit_d;
    logic [16:0] sample_cnt_q, sample_cnt_d;
    logic        trunc_q, trunc_d;
    logic [63:0] ts_q, ts_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [16:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] pulse_count_q, pulse_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        overflow_q, overflow_d;
    logic [31:0] rdata_q;
    logic [31:0] mem [0:(1<<FIFO_AW)-1];

    logic        w_rise, w_fall, w_sample, w_cfg_wr;
    logic [16:0] w_limit_new, w_cap_lim, w_cap_cnt;
    logic        w_cap_active, w_wr_en, w_ovf_set, w_accept;

    assign w_rise       = en_q & ~en2_q;
    assign w_fall       = ~en_q & en2_q;
    assign w_sample     = en_q & vld_q;
    assign w_cfg_wr     = set_stb && (set_addr == SR_CAPTURE_MAX_ADDR);
    // Limit never exceeds the buffer depth; a zero setting captures nothing.
    assign w_limit_new  = ({1'b0, capture_max_q} > DEPTH) ? DEPTH[16:0] : capture_max_q[16:0];
    // The rising-edge cycle in IDLE is already the first capture cycle.
    assign w_cap_active = ((state_q == S_IDLE) && w_rise) || (state_q == S_CAPTURE);
    assign w_cap_lim    = (state_q == S_IDLE) ? w_limit_new : limit_q;
    assign w_cap_cnt    = (state_q == S_IDLE) ? 17'd0 : sample_cnt_q;

    assign pulse_count  = pulse_count_q;
    assign drop_count   = drop_count_q;
    assign overflow     = overflow_q;

    // Input pipeline: enable, qualifier and data stay aligned after registering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q  <= 1'b0;
            en2_q <= 1'b0;
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            en_q  <= adc_enable;
            en2_q <= en_q;
            vld_q <= adc_valid;
            dat_q <= adc_data;
        end
    end

    // Settings register holding the max samples per pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capture_max_q <= CAPTURE_MAX_INIT;
        end else if (w_cfg_wr) begin
            capture_max_q <= set_data;
        end
    end

    // Next-state, datapath and AXI-Stream output decode.
    always_comb begin
        state_d       = state_q;
        limit_d       = limit_q;
        sample_cnt_d  = sample_cnt_q;
        trunc_d       = trunc_q;
        ts_d          = ts_q;
        hdr_idx_d     = hdr_idx_q;
        rd_ptr_d      = rd_ptr_q;
        pulse_count_d = pulse_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        w_wr_en       = 1'b0;
        w_ovf_set     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        w_accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_rise) begin
                    ts_d         = timestamp;
                    limit_d      = w_limit_new;
                    sample_cnt_d = '0;
                    trunc_d      = 1'b0;
                    rd_ptr_d     = '0;
                    state_d      = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_fall) begin
                    hdr_idx_d = 2'd0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                m_axis_tvalid = 1'b1;
                case (hdr_idx_q)
                    2'd0:    m_axis_tdata = {HDR_MAGIC, pulse_count_q};
                    2'd1:    m_axis_tdata = {trunc_q, 14'b0, sample_cnt_q};
                    2'd2:    m_axis_tdata = ts_q[63:32];
                    default: m_axis_tdata = ts_q[31:0];
                endcase
                m_axis_tlast = (hdr_idx_q == 2'd3) && (sample_cnt_q == 17'd0);
                w_accept     = m_axis_tready;
                if (w_accept) begin
                    if (hdr_idx_q != 2'd3) begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end else if (sample_cnt_q != 17'd0) begin
                        state_d = S_DATA;
                    end else begin
                        pulse_count_d = pulse_count_q + 16'd1;
                        state_d       = S_IDLE;
                    end
                end
            end
            default: begin
                // rdata_q already holds mem[rd_ptr_q]; a new read is issued
                // with the post-accept pointer so streaming has no bubbles.
                m_axis_tvalid = (rd_ptr_q < sample_cnt_q);
                m_axis_tdata  = rdata_q;
                m_axis_tlast  = (rd_ptr_q == sample_cnt_q - 17'd1);
                w_accept      = m_axis_tvalid && m_axis_tready;
                if (w_accept) begin
                    rd_ptr_d = rd_ptr_q + 17'd1;
                    if (m_axis_tlast) begin
                        pulse_count_d = pulse_count_q + 16'd1;
                        state_d       = S_IDLE;
                    end
                end
            end
        endcase

        if (w_cap_active && w_sample) begin
            if (w_cap_cnt < w_cap_lim) begin
                w_wr_en      = 1'b1;
                sample_cnt_d = w_cap_cnt + 17'd1;
            end else begin
                trunc_d   = 1'b1;
                w_ovf_set = 1'b1;
            end
        end

        if (w_rise && ((state_q == S_HDR) || (state_q == S_DATA)) && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        if (w_cfg_wr) begin
            overflow_d = 1'b0;
        end
        if (w_ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            limit_q       <= '0;
            sample_cnt_q  <= '0;
            trunc_q       <= 1'b0;
            ts_q          <= '0;
            hdr_idx_q     <= '0;
            rd_ptr_q      <= '0;
            pulse_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            limit_q       <= limit_d;
            sample_cnt_q  <= sample_cnt_d;
            trunc_q       <= trunc_d;
            ts_q          <= ts_d;
            hdr_idx_q     <= hdr_idx_d;
            rd_ptr_q      <= rd_ptr_d;
            pulse_count_q <= pulse_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
        end
    end

    // Sample buffer: write in capture order, registered read at the next pointer.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[w_cap_cnt[FIFO_AW-1:0]] <= dat_q;
        end
        rdata_q <= mem[rd_ptr_d[FIFO_AW-1:0]];
    end

endmodule
`default_nettype wire

// File: tb/tb_radar_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_radar_adc_capture
// Description : Randomized scoreboard bench for radar_adc_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radar_adc_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        adc_enable = 1'b0;
    logic        adc_valid = 1'b0;
    logic [31:0] adc_data = '0;
    logic [63:0] timestamp = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic [15:0] pulse_count;
    logic [15:0] drop_count;
    logic        overflow;

    radar_adc_capture dut (
        .clk           (clk),
        .reset         (reset),
        .set_stb       (set_stb),
        .set_addr      (set_addr),
        .set_data      (set_data),
        .adc_enable    (adc_enable),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .timestamp     (timestamp),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pulse_count   (pulse_count),
        .drop_count    (drop_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          acc_cnt = 0;
    logic        rand_ready = 1'b0;
    logic        ready_fixed = 1'b0;

    // Reference model state
    logic [31:0] model_cap = 32'h000001fe;
    logic [15:0] exp_pulse = '0;
    logic [15:0] exp_drop = '0;
    logic        exp_ovf = 1'b0;

    // Downstream ready: either a fixed level or a random 50% pattern.
    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Monitor: pops the scoreboard on every accepted beat and checks hold rules.
    logic        stall_q = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (!(m_axis_tvalid && m_axis_tdata == prev_d && m_axis_tlast == prev_l)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%h l=%0b, need v=1 d=%h l=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got d=%h l=%0b, need no beat",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    e = sb.pop_front();
                    if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
                        errors++;
                        $display("FAIL beat: got d=%h l=%0b, need d=%h l=%0b",
                                 m_axis_tdata, m_axis_tlast, e.d, e.l);
                    end
                end
                acc_cnt++;
            end
            stall_q = m_axis_tvalid && !m_axis_tready;
            prev_d  = m_axis_tdata;
            prev_l  = m_axis_tlast;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, act, expv);
        end
    endtask

    task automatic write_cap(input logic [31:0] v);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = 8'd3; set_data = v;
        @(posedge clk); #1;
        set_stb = 1'b0;
        model_cap = v;
        exp_ovf   = 1'b0;
    endtask

    // Frame expected from the captured sample list and the current limit.
    task automatic push_frame(input logic [63:0] ts, input logic [31:0] smp[$]);
        int   lim;
        int   kept;
        logic tr;
        lim  = (model_cap > 32'd1024) ? 1024 : int'(model_cap);
        kept = (smp.size() < lim) ? smp.size() : lim;
        tr   = (smp.size() > lim);
        if (tr) exp_ovf = 1'b1;
        sb.push_back('{d: {16'hADC0, exp_pulse}, l: 1'b0});
        sb.push_back('{d: {tr, 14'b0, 17'(kept)}, l: 1'b0});
        sb.push_back('{d: ts[63:32], l: 1'b0});
        sb.push_back('{d: ts[31:0], l: (kept == 0)});
        for (int i = 0; i < kept; i++) begin
            sb.push_back('{d: smp[i], l: (i == kept - 1)});
        end
        exp_pulse = exp_pulse + 16'd1;
    endtask

    // One adc_enable window of n cycles; vmode 0=no valid, 1=all valid, 2=random.
    task automatic pulse(input int n, input int vmode, input bit dropped);
        logic [31:0] smp[$];
        logic [63:0] ts;
        ts = {$urandom(), $urandom()};
        timestamp = ts;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 3) timestamp = ts + 64'd977;
            adc_enable = 1'b1;
            adc_valid  = (vmode == 1) ? 1'b1 : (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            adc_data   = $urandom();
            if (adc_valid) smp.push_back(adc_data);
        end
        if (!dropped) chk("tvalid_in_capture", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk); #1;
        adc_enable = 1'b0;
        adc_valid  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        timestamp = ts + 64'd5000;
        if (dropped) exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
        else         push_frame(ts, smp);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words left, need 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (acc_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got %0d beats, need %0d", acc_cnt, target);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset_counts", {31'd0, overflow, drop_count, pulse_count}, 64'd0);
        reset = 1'b0;
        ready_fixed = 1'b1;
        repeat (2) @(posedge clk);

        // Eight valid samples, default limit
        pulse(8, 1, 1'b0);
        wait_drain();
        chk("pulse_count_1", 64'(pulse_count), 64'(exp_pulse));

        // 300-sample frame with random backpressure
        rand_ready = 1'b1;
        pulse(300, 1, 1'b0);
        wait_drain();
        rand_ready = 1'b0;
        chk("pulse_count_2", 64'(pulse_count), 64'(exp_pulse));

        // Window with no valid samples: header-only frame
        pulse(5, 0, 1'b0);
        wait_drain();

        // Truncation at a limit of 4
        write_cap(32'd4);
        pulse(10, 1, 1'b0);
        wait_drain();
        chk("overflow_set", 64'(overflow), 64'(exp_ovf));
        write_cap(32'h000001fe);
        chk("overflow_cleared", 64'(overflow), 64'd0);

        // Random windows against random small limits
        rand_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            write_cap(32'($urandom_range(0, 24)));
            pulse($urandom_range(1, 30), 2, 1'b0);
            wait_drain();
            chk("overflow_random", 64'(overflow), 64'(exp_ovf));
        end
        rand_ready = 1'b0;
        write_cap(32'h000001fe);

        // Pulse arriving while the previous frame is stalled in DATA
        pulse(12, 1, 1'b0);
        wait_acc(acc_cnt + 6);
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        pulse(4, 1, 1'b1);
        ready_fixed = 1'b1;
        wait_drain();
        chk("drop_count", 64'(drop_count), 64'(exp_drop));
        pulse(6, 2, 1'b0);
        wait_drain();
        chk("pulse_after_drop", 64'(pulse_count), 64'(exp_pulse));

        // Reset in the middle of DATA
        pulse(20, 1, 1'b0);
        wait_acc(acc_cnt + 8);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("reset_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset_mid_counts", {31'd0, overflow, drop_count, pulse_count}, 64'd0);
        sb.delete();
        exp_pulse = '0;
        exp_drop  = '0;
        exp_ovf   = 1'b0;
        model_cap = 32'h000001fe;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        pulse(7, 1, 1'b0);
        wait_drain();
        chk("pulse_after_reset", 64'(pulse_count), 64'd1);
        chk("drop_after_reset", 64'(drop_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
